// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline-register chain.
// Helpers are sized for up to MaxStages stages.
package pipe_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefStages = 5;
  localparam int unsigned MaxStages = 32;

  // Stall index beyond the last stage holds the whole pipe.
  function automatic int unsigned clamp_stage(input int unsigned idx, input int unsigned stages);
    return (idx >= stages) ? stages - 1 : idx;
  endfunction

  function automatic int unsigned popcount(input logic [MaxStages-1:0] bits);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MaxStages; i++) begin
      if (bits[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One valid/payload stage register with load, bubble, hold and clear controls.
// The payload only changes when a valid item is loaded, so bubbles keep stale data.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clear,
  output logic             valid,
  output logic             valid_next,
  output logic [WIDTH-1:0] data
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (load) begin
      v_d = load_valid;
      if (load_valid) d_d = load_data;
    end
    // Clear overrides load, hold and bubble.
    if (clear) v_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid      = v_q;
  assign valid_next = v_d;
  assign data       = d_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic STAGES-deep pipeline-register chain with valid/ready at both ends,
// prefix hazard stall, per-stage flush, stage export, occupancy and stall counter.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages,
  parameter int unsigned IDXW   = $clog2(STAGES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  input  logic                    stall_en,
  input  logic [IDXW-1:0]         stall_stage,
  input  logic [STAGES-1:0]       flush_mask,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic [IDXW:0]           occupancy,
  output logic [15:0]             stall_cycles
);

  logic [STAGES-1:0] v, v_next, held, move;
  logic [STAGES:0]   free_up;
  logic [STAGES-1:0] ld_valid;
  logic [WIDTH-1:0]  d       [STAGES];
  logic [WIDTH-1:0]  ld_data [STAGES];
  int unsigned       stall_lim;

  logic [IDXW:0] occupancy_q;
  logic [15:0]   stall_cycles_q;

  // Advance chain resolved from the output end; free_up[STAGES] is the downstream ready.
  always_comb begin
    stall_lim = clamp_stage(32'(stall_stage), STAGES);
    held      = '0;
    move      = '0;
    free_up   = '0;
    free_up[STAGES] = out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      held[k] = stall_en && (k <= stall_lim);
    end
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      move[k]    = v[k] && free_up[k+1] && !held[k];
      free_up[k] = !held[k] && (!v[k] || move[k]);
    end
  end

  assign ld_valid = {move[STAGES-2:0], in_valid};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign ld_data[k] = in_data;
    end else begin : g_body
      assign ld_data[k] = d[k-1];
    end

    pipe_stage_reg #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (free_up[k]),
      .load_valid(ld_valid[k]),
      .load_data (ld_data[k]),
      .clear     (flush_mask[k]),
      .valid     (v[k]),
      .valid_next(v_next[k]),
      .data      (d[k])
    );

    assign stage_data[k*WIDTH +: WIDTH] = d[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      occupancy_q <= (IDXW+1)'(popcount(MaxStages'(v_next)));
      if (stall_en && (stall_cycles_q != 16'hFFFF)) stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign in_ready     = free_up[0] && !reset;
  assign out_valid    = v[STAGES-1];
  assign out_data     = d[STAGES-1];
  assign stage_valid  = v;
  assign occupancy    = occupancy_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised elastic pipeline-register chain that replaces the hand-wired chain of fixed-width stage registers between processor stages. It carries a WIDTH-bit payload through STAGES registered stages with per-stage valid bits, a valid/ready handshake at both ends, a hazard stall that holds a prefix of the pipe and inserts a bubble behind it, and per-stage selective flush. Every stage's contents are exported for forwarding and hazard logic. It sits between the fetch and write-back logic of the processor top.

## Interface
- WIDTH, 16, payload bits per stage
- STAGES, 5, number of pipeline stages (≥2)
- IDXW, $clog2(STAGES), width of stage index
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- in_valid  in  1  upstream payload valid
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  stage 0 accepts this cycle (combinational)
- out_valid  out  1  stage STAGES-1 holds valid payload
- out_data  out  WIDTH  stage STAGES-1 payload
- out_ready  in  1  downstream consumes stage STAGES-1
- stall_en  in  1  hazard stall request
- stall_stage  in  IDXW  highest stage index held by the stall
- flush_mask  in  STAGES  bit k invalidates stage k at next edge
- stage_valid  out  STAGES  valid bit of every stage
- stage_data  out  STAGES*WIDTH  stage k payload at bits [k*WIDTH +: WIDTH]
- occupancy  out  IDXW+1  registered count of valid stages
- stall_cycles  out  16  saturating count of cycles with stall_en=1

## Operation
- State per stage k: v[k], d[k]. out_valid=v[STAGES-1], out_data=d[STAGES-1].
- held[k] = stall_en && k ≤ stall_stage; stall_stage ≥ STAGES clamps to STAGES-1 (whole pipe held).
- Advance chain, evaluated from last stage down: move[STAGES-1] = v[STAGES-1] && out_ready && !held[STAGES-1]; move[k] = v[k] && free[k+1] && !held[k]; free[k] = !held[k] && (!v[k] || move[k]).
- Stage k>0 with free[k]: loads d[k-1] and v[k]=move[k-1]; if stage k-1 does not move, stage k becomes a bubble (v=0, d unchanged).
- Stage 0: in_ready = free[0] && !reset; when free[0], v[0]=in_valid, d[0]=in_data if in_valid.
- Held stages keep v and d; the first non-held stage behind the stall receives a bubble.
- Not free and not held (back-pressured): stage keeps contents.
- Flush: flush_mask[k]=1 forces v[k]=0 at the next edge, overriding load, hold and bubble; d[k] is don't-care. A flushed stage still passes its current content downstream this cycle if move[k]=1 (flush applies to the stage's next state, not its output).
- in_ready is not gated by flush_mask[0]; an input accepted while flush_mask[0]=1 is dropped.
- occupancy = popcount of next-state v, registered.
- stall_cycles increments when stall_en=1, saturates at 16'hFFFF.

## Timing
- Reset (synchronous, high): all v=0, all d=0, occupancy=0, stall_cycles=0; out_valid=0, stage_valid=0, in_ready=0 while reset is high, in_ready=1 on the first cycle after reset.
- Latency: payload accepted at edge t appears on out_data from edge t+STAGES-1 onward when unobstructed; throughput one payload per cycle.
- in_ready depends combinationally on out_ready, stall_en, stall_stage; no combinational path from in_valid/in_data to outputs.
- Full pipe with out_ready=0: in_ready=0, no stage changes, no data lost.
- Stall and flush on the same stage in the same cycle: flush wins (v=0).
- Release of stall: held stages resume movement in the same cycle stall_en drops.

## Structure
- Shared package pipe_pkg: default WIDTH/STAGES constants and the clamped-index and popcount helper functions.
- One sub-module pipe_stage_reg (v/d register with load, hold, bubble, clear controls), instantiated STAGES times by generate; advance/ready chain, counters and occupancy live in the top.

## Test plan
- Streaming: STAGES=5, in_valid=1 with data 1,2,3… and out_ready=1 → out_data=1 appears 4 cycles after first accept, then one value per cycle, occupancy=5.
- Back-pressure: fill pipe, out_ready=0 for 3 cycles → in_ready=0, stage_data frozen, then out_ready=1 drains in order with no loss or duplicate.
- Hazard stall: stall_en=1, stall_stage=1 for 2 cycles mid-stream → stages 0–1 hold, stage 2 shows two bubbles, stall_cycles=2.
- Flush: flush_mask=5'b00111 with all stages valid → next cycle stage_valid=5'b11000, occupancy=2; flush combined with stall on stage 1 leaves v[1]=0.
- Reset mid-stream: assert reset for one cycle with full pipe → next cycle out_valid=0, occupancy=0, stall_cycles=0, in_ready=1.
- Saturation: hold stall_en=1 for 65540 cycles → stall_cycles=16'hFFFF.
